rdc_apb_sample_fifo: RTL and testbench
======================================

RDC_APB_SAMPLE_FIFO -- requirements
Module: rdc_apb_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter SMP_W, default 16, sample width in bits (<=32).
REQ-003 SHALL have port sys_clk, input, 1, the single clock, shared with the EMPU APB master.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port paddr, input, 8, APB byte address.
REQ-006 SHALL have ports psel, penable, pwrite, each input, 1, APB3 controls.
REQ-007 SHALL have port pwdata, input, 32, APB write data.
REQ-008 SHALL have port pstrb, input, 4, APB write strobes.
REQ-009 SHALL have port prdata, output, 32, APB read data.
REQ-010 SHALL have port pready, output, 1, APB ready.
REQ-011 SHALL have port pslverr, output, 1, APB error.
REQ-012 SHALL have port smp_valid, input, 1, one-cycle sample strobe from the upstream RDC datapath.
REQ-013 SHALL have port smp_data, input, SMP_W, resolver angle sample.
REQ-014 SHALL have port user_int, output, 1, level interrupt to the EMPU user_int_0 input.

Function
REQ-015 SHALL drive pready=1 constantly: every transfer is setup + one access cycle; side effects occur only on the access cycle (psel&penable).
REQ-016 SHALL decode the register map: 0x00 CTRL (RW), 0x04 STATUS (R/W1C), 0x08 DATA (RO, pop), 0x0C THRESH (RW).
REQ-017 CTRL SHALL contain bit0 EN (RW) and bit1 CLR (write-1 self-clearing, reads 0); other bits read 0.
REQ-018 STATUS SHALL contain [6:0] COUNT, bit8 EMPTY, bit9 FULL, bit10 OVF (sticky, cleared by writing 1 to bit10).
REQ-019 THRESH SHALL contain [6:0] interrupt level; other bits read 0.
REQ-020 SHALL drive prdata combinationally from the addressed register while psel=1 with pwrite=0, else 32'h0.
REQ-021 A DATA read SHALL return the head entry zero-extended and pop it at the access cycle.
REQ-022 A DATA read while EMPTY SHALL return 0, assert pslverr, and not pop.
REQ-023 SHALL assert pslverr in the access cycle for paddr[1:0]!=0, paddr>0x0C, or any write to DATA; such accesses SHALL have no side effect.
REQ-024 Writes SHALL update registers only when pstrb[0]=1; pstrb[0]=0 SHALL be a silent no-op.
REQ-025 smp_valid with EN=1 and not FULL SHALL push smp_data; COUNT reflects it the next cycle.
REQ-026 smp_valid with EN=1 and FULL SHALL drop the sample and set OVF; the FIFO contents SHALL be unchanged.
REQ-027 smp_valid with EN=0 SHALL be ignored without setting OVF.
REQ-028 Simultaneous push and pop when FULL SHALL accept both; COUNT stays DEPTH, OVF not set.
REQ-029 Simultaneous push and DATA read when EMPTY SHALL accept the push and error the read.
REQ-030 CLR SHALL empty the FIFO and clear OVF in the same cycle; a coincident push SHALL be discarded without setting OVF.
REQ-031 Read/write pointers SHALL wrap modulo DEPTH; COUNT SHALL be log2(DEPTH)+1 bits and saturate at neither end outside REQ-026/REQ-022.
REQ-032 user_int SHALL be registered: 1 the cycle after EN=1, THRESH!=0 and COUNT>=THRESH hold, 0 otherwise.

Reset
REQ-033 reset_n low SHALL immediately clear EN, THRESH, OVF, pointers and COUNT, and set user_int=0; outputs SHALL read pready=1, pslverr=0, prdata=0.
REQ-034 Reset mid-transfer SHALL abort it; no pop or register write SHALL survive reset.

Structure
REQ-035 Register offsets, bit positions and the DEPTH default SHALL live in shared package rdc_apb_pkg.
REQ-036 Storage and pointer/count logic SHALL be sub-module rdc_sample_fifo (push, pop, clear, full, empty, count); register decode stays in the top.

Verification
REQ-037 Reset, write CTRL=0x1, push 0x1234 and 0xABCD -> STATUS=0x002; DATA reads 0x1234 then 0xABCD; STATUS=0x100.
REQ-038 THRESH=4, push 4 samples -> user_int rises one cycle after the 4th push; one DATA read -> user_int falls one cycle later.
REQ-039 Push DEPTH+1 samples -> STATUS FULL=1, OVF=1, COUNT=DEPTH; write STATUS=0x400 -> OVF=0; FIFO data intact.
REQ-040 FULL, push and DATA read in the same cycle -> oldest entry returned, COUNT=DEPTH, OVF=0, new sample at tail.
REQ-041 DATA read when empty, read 0x10, write DATA -> each pslverr=1, prdata=0, no state change.
REQ-042 3 entries, write CTRL=0x3 coincident with smp_valid -> COUNT=0, OVF=0, EN=1, CTRL reads 0x1.

Source files
------------

// File: rtl/rdc_apb_pkg.sv
// Shared register map, bit positions and defaults for the RDC sample FIFO APB slave.
package rdc_apb_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int CNT_FW    = 7;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_DATA   = 8'h08;
    localparam logic [7:0] ADDR_THRESH = 8'h0C;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CLR_BIT   = 1;
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_OVF_BIT   = 10;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_DATA   = 2'd2,
        REG_THRESH = 2'd3
    } reg_sel_e;

    // Word-aligned and inside the four-register window.
    function automatic logic addr_valid(input logic [7:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= ADDR_THRESH);
    endfunction

endpackage

// File: rtl/rdc_sample_fifo.sv
// Sample storage with wrapping pointers and an occupancy count; clear dominates push/pop.
module rdc_sample_fifo #(
    parameter  int DEPTH = 16,
    parameter  int W     = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rdc_apb_sample_fifo.sv
// APB3 slave buffering resolver angle samples for the EMPU, with threshold interrupt.
module rdc_apb_sample_fifo
    import rdc_apb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int SMP_W = 16
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic [7:0]       paddr,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [31:0]      pwdata,
    input  logic [3:0]       pstrb,
    output logic [31:0]      prdata,
    output logic             pready,
    output logic             pslverr,
    input  logic             smp_valid,
    input  logic [SMP_W-1:0] smp_data,
    output logic             user_int
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             en;
    logic             ovf;
    logic [6:0]       thresh;
    logic [CW-1:0]    fifo_count;
    logic [6:0]       cnt7;
    logic             fifo_full;
    logic             fifo_empty;
    logic [SMP_W-1:0] head;
    logic [31:0]      status_word;
    logic [31:0]      rd_mux;

    logic     access;
    logic     addr_ok;
    reg_sel_e sel;
    logic     wr_en;
    logic     pop;
    logic     clr;
    logic     push_req;
    logic     push;
    logic     ovf_set;

    assign access  = psel & penable;
    assign addr_ok = addr_valid(paddr);
    assign sel     = reg_sel_e'(paddr[3:2]);

    assign wr_en = access & pwrite & addr_ok & pstrb[0] & (sel != REG_DATA);
    assign pop   = access & ~pwrite & addr_ok & (sel == REG_DATA) & ~fifo_empty;
    assign clr   = wr_en & (sel == REG_CTRL) & pwdata[CTRL_CLR_BIT];

    // A clear wipes the FIFO outright, so a coincident sample is neither stored nor an overflow.
    assign push_req = smp_valid & en & ~clr;
    assign push     = push_req & (~fifo_full | pop);
    assign ovf_set  = push_req & fifo_full & ~pop;

    assign pready  = 1'b1;
    assign pslverr = reset_n & access &
                     (~addr_ok | (pwrite & (sel == REG_DATA)) |
                      (~pwrite & (sel == REG_DATA) & fifo_empty));

    assign cnt7 = 7'(fifo_count);

    always_comb begin
        status_word                 = '0;
        status_word[CNT_FW-1:0]     = cnt7;
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_OVF_BIT]   = ovf;
    end

    always_comb begin
        rd_mux = '0;
        if (reset_n && psel && !pwrite && addr_ok) begin
            case (sel)
                REG_CTRL:   rd_mux[CTRL_EN_BIT] = en;
                REG_STATUS: rd_mux = status_word;
                REG_DATA:   if (!fifo_empty) rd_mux[SMP_W-1:0] = head;
                REG_THRESH: rd_mux[6:0] = thresh;
                default:    rd_mux = '0;
            endcase
        end
    end
    assign prdata = rd_mux;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            en       <= 1'b0;
            thresh   <= '0;
            ovf      <= 1'b0;
            user_int <= 1'b0;
        end else begin
            if (wr_en && sel == REG_CTRL)   en     <= pwdata[CTRL_EN_BIT];
            if (wr_en && sel == REG_THRESH) thresh <= pwdata[6:0];
            if (clr)
                ovf <= 1'b0;
            else if (ovf_set)
                ovf <= 1'b1;
            else if (wr_en && sel == REG_STATUS && pwdata[STAT_OVF_BIT])
                ovf <= 1'b0;
            user_int <= en && (thresh != '0) && (cnt7 >= thresh);
        end
    end

    rdc_sample_fifo #(
        .DEPTH (DEPTH),
        .W     (SMP_W)
    ) u_fifo (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .clr     (clr),
        .wdata   (smp_data),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    logic unused_bits;
    assign unused_bits = ^{pwdata[31:11], pwdata[9:7], pstrb[3:1]};

endmodule

// File: tb/tb_rdc_apb_sample_fifo.sv
// Directed bench: APB accesses queue expected prdata/pslverr; a monitor compares at each access cycle.
module tb_rdc_apb_sample_fifo;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic        user_int;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t  eq[$];
    string nq[$];
    logic  uq[$];
    string unq[$];
    logic  ui_chk = 1'b0;

    rdc_apb_sample_fifo #(.DEPTH(16), .SMP_W(16)) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .user_int  (user_int)
    );

    always #5 sys_clk = ~sys_clk;

    // Monitor: the only place checks are counted.
    always @(negedge sys_clk) begin
        if (psel && penable) begin
            checks++;
            if (eq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_access: prdata=%h pslverr=%b, no expectation queued", prdata, pslverr);
            end else begin
                exp_t  e;
                string n;
                e = eq.pop_front();
                n = nq.pop_front();
                if (prdata !== e.rd || pslverr !== e.err || pready !== 1'b1) begin
                    failures++;
                    $display("FAIL %s: got prdata=%h pslverr=%b pready=%b, want prdata=%h pslverr=%b pready=1",
                             n, prdata, pslverr, pready, e.rd, e.err);
                end
            end
        end
        if (ui_chk) begin
            checks++;
            if (uq.size() == 0) begin
                failures++;
                $display("FAIL ui_unexpected: user_int=%b, no expectation queued", user_int);
            end else begin
                logic  eu;
                string n;
                eu = uq.pop_front();
                n  = unq.pop_front();
                if (user_int !== eu) begin
                    failures++;
                    $display("FAIL %s: got user_int=%b, want %b", n, user_int, eu);
                end
            end
        end
    end

    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_rd, input logic exp_err, input string nm,
                       input logic sv = 1'b0, input logic [15:0] sd = 16'h0);
        @(posedge sys_clk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge sys_clk) #1;
        penable = 1'b1;
        smp_valid = sv; smp_data = sd;
        eq.push_back('{rd: exp_rd, err: exp_err});
        nq.push_back(nm);
        @(posedge sys_clk) #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; smp_valid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input string nm);
        apb(1'b1, a, d, 4'hF, 32'h0, 1'b0, nm);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        apb(1'b0, a, 32'h0, 4'h0, e, 1'b0, nm);
    endtask

    task automatic smp(input logic [15:0] d);
        @(posedge sys_clk) #1;
        smp_valid = 1'b1; smp_data = d;
        @(posedge sys_clk) #1;
        smp_valid = 1'b0;
    endtask

    task automatic chk_ui(input logic e, input string nm);
        uq.push_back(e);
        unq.push_back(nm);
        ui_chk = 1'b1;
        @(posedge sys_clk) #1;
        ui_chk = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0; smp_valid = 1'b0; smp_data = 16'h0;

        // Access held during reset must show quiet outputs.
        @(posedge sys_clk) #1;
        psel = 1'b1; penable = 1'b1; paddr = 8'h04;
        eq.push_back('{rd: 32'h0, err: 1'b0}); nq.push_back("rst_outputs");
        @(posedge sys_clk) #1;
        psel = 1'b0; penable = 1'b0; paddr = 8'h0;
        @(posedge sys_clk) #1;
        reset_n = 1'b1;

        rd(8'h00, 32'h0,   "rst_ctrl");
        rd(8'h04, 32'h100, "rst_status");
        rd(8'h0C, 32'h0,   "rst_thresh");
        chk_ui(1'b0, "rst_user_int");

        // Basic push/pop ordering.
        wr(8'h00, 32'h1, "ctrl_en");
        smp(16'h1234);
        smp(16'hABCD);
        rd(8'h04, 32'h002,  "status_two");
        rd(8'h08, 32'h1234, "data_first");
        rd(8'h08, 32'hABCD, "data_second");
        rd(8'h04, 32'h100,  "status_empty");

        // Threshold interrupt.
        wr(8'h0C, 32'hFFFF_FF84, "thresh_wr");
        rd(8'h0C, 32'h4, "thresh_rd");
        smp(16'h0001); smp(16'h0002); smp(16'h0003);
        chk_ui(1'b0, "ui_below");
        smp(16'h0004);
        chk_ui(1'b0, "ui_pre_rise");
        chk_ui(1'b1, "ui_rise");
        rd(8'h08, 32'h1, "ui_pop");
        chk_ui(1'b1, "ui_pre_fall");
        chk_ui(1'b0, "ui_fall");
        rd(8'h08, 32'h2, "drain_2");
        rd(8'h08, 32'h3, "drain_3");
        rd(8'h08, 32'h4, "drain_4");
        wr(8'h0C, 32'h0, "thresh_off");

        // Overflow, W1C, strobe no-op.
        for (int i = 0; i < 17; i++) smp(16'h0100 + 16'(i));
        rd(8'h04, 32'h610, "status_ovf");
        apb(1'b1, 8'h04, 32'h400, 4'h0, 32'h0, 1'b0, "w1c_nostrb");
        rd(8'h04, 32'h610, "status_ovf_kept");
        wr(8'h04, 32'h400, "w1c_ovf");
        rd(8'h04, 32'h210, "status_ovf_clr");

        // Full with simultaneous push and pop.
        apb(1'b0, 8'h08, 32'h0, 4'h0, 32'h100, 1'b0, "full_pushpop", 1'b1, 16'hBEEF);
        rd(8'h04, 32'h210, "status_full_kept");
        for (int i = 1; i < 16; i++) rd(8'h08, 32'h100 + 32'(i), "intact_data");
        rd(8'h08, 32'hBEEF, "tail_new");
        rd(8'h04, 32'h100, "status_drained");

        // Error cases.
        apb(1'b0, 8'h08, 32'h0, 4'h0, 32'h0, 1'b1, "err_empty_rd");
        apb(1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b1, "err_oob_rd");
        apb(1'b1, 8'h08, 32'h55, 4'hF, 32'h0, 1'b1, "err_data_wr");
        apb(1'b0, 8'h05, 32'h0, 4'h0, 32'h0, 1'b1, "err_unaligned");
        rd(8'h04, 32'h100, "err_no_change");
        rd(8'h00, 32'h1, "err_ctrl_kept");

        // Push coincident with errored empty read.
        apb(1'b0, 8'h08, 32'h0, 4'h0, 32'h0, 1'b1, "empty_rd_push", 1'b1, 16'h5555);
        rd(8'h04, 32'h001, "status_one");
        rd(8'h08, 32'h5555, "data_5555");

        // Clear with coincident push.
        smp(16'h0A0A); smp(16'h0B0B); smp(16'h0C0C);
        rd(8'h04, 32'h003, "status_three");
        apb(1'b1, 8'h00, 32'h3, 4'h1, 32'h0, 1'b0, "ctrl_clr", 1'b1, 16'h0D0D);
        rd(8'h04, 32'h100, "status_after_clr");
        rd(8'h00, 32'h1, "ctrl_after_clr");

        // Disabled pushes ignored.
        wr(8'h00, 32'h0, "ctrl_dis");
        smp(16'h7777);
        rd(8'h04, 32'h100, "status_disabled");

        repeat (3) @(posedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
